// File: rtl/acc_alu_seq.sv
// acc_alu_seq: WIDTH-bit accumulator ALU with an NREGS-deep operand register file.
// Commands arrive over a valid/ready handshake. Most ops finish in one cycle.
// MUL is a WIDTH-cycle shift-add sequence. OUT drives the bus for one cycle.
module acc_alu_seq #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int SELW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [SELW-1:0]   cmd_sel,
   input  logic [WIDTH-1:0]  cmd_data,
   output logic [WIDTH-1:0]  acc_out,
   output logic [WIDTH-1:0]  hi_out,
   output logic [WIDTH-1:0]  bus_out,
   output logic              bus_oe,
   output logic              cf,
   output logic              zf,
   output logic              nf,
   output logic              vf,
   output logic              busy,
   output logic              done
);

   localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,  OP_LDA = 4'd1,  OP_LDB = 4'd2,  OP_ADD = 4'd3,
      OP_SUB = 4'd4,  OP_ADC = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
      OP_XOR = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_MUL = 4'd11,
      OP_OUT = 4'd12, OP_CLR = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
   } op_t;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t              state_q;
   op_t                 op;
   logic [WIDTH-1:0]    acc_q;
   logic [WIDTH-1:0]    hi_q;
   logic [WIDTH-1:0]    b_q [NREGS];
   logic                cf_q;
   logic                zf_q;
   logic                nf_q;
   logic                vf_q;
   logic                done_q;
   logic                oe_q;
   logic                busy_q;
   logic [CNTW-1:0]     cnt_q;
   logic [WIDTH-1:0]    mcand_q;
   logic [2*WIDTH-1:0]  prod_q;

   logic [WIDTH-1:0]    b_val;
   logic [WIDTH:0]      sum_ext;
   logic [WIDTH-1:0]    res;
   logic                c_n;
   logic                v_n;
   logic                wr_acc;
   logic [WIDTH:0]      step_sum;
   logic [2*WIDTH-1:0]  prod_nxt;

   assign op        = op_t'(cmd_op);
   assign cmd_ready = (state_q == S_IDLE);
   assign acc_out   = acc_q;
   assign hi_out    = hi_q;
   assign bus_oe    = oe_q;
   assign bus_out   = oe_q ? acc_q : '0;
   assign cf        = cf_q;
   assign zf        = zf_q;
   assign nf        = nf_q;
   assign vf        = vf_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Single-cycle ALU result and flag candidates for the command on the inputs.
   // The register read loops over valid indices, so an out-of-range select reads 0.
   always_comb begin
      b_val = '0;
      for (int unsigned i = 0; i < unsigned'(NREGS); i++) begin
         if (cmd_sel == SELW'(i)) b_val = b_q[i];
      end
      sum_ext = '0;
      res     = acc_q;
      c_n     = cf_q;
      v_n     = vf_q;
      wr_acc  = 1'b0;
      case (op)
         OP_LDA: begin
            res    = cmd_data;
            wr_acc = 1'b1;
         end
         OP_ADD, OP_ADC: begin
            sum_ext = {1'b0, acc_q} + {1'b0, b_val};
            if (op == OP_ADC) sum_ext = sum_ext + {{WIDTH{1'b0}}, cf_q};
            res    = sum_ext[WIDTH-1:0];
            c_n    = sum_ext[WIDTH];
            v_n    = (acc_q[WIDTH-1] == b_val[WIDTH-1]) && (res[WIDTH-1] != acc_q[WIDTH-1]);
            wr_acc = 1'b1;
         end
         OP_SUB: begin
            sum_ext = {1'b0, acc_q} - {1'b0, b_val};
            res    = sum_ext[WIDTH-1:0];
            c_n    = sum_ext[WIDTH];
            v_n    = (acc_q[WIDTH-1] != b_val[WIDTH-1]) && (res[WIDTH-1] != acc_q[WIDTH-1]);
            wr_acc = 1'b1;
         end
         OP_AND: begin
            res    = acc_q & b_val;
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         OP_OR: begin
            res    = acc_q | b_val;
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         OP_XOR: begin
            res    = acc_q ^ b_val;
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         OP_SHL: begin
            res    = acc_q << 1;
            c_n    = acc_q[WIDTH-1];
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         OP_SHR: begin
            res    = acc_q >> 1;
            c_n    = acc_q[0];
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         OP_CLR: begin
            res    = '0;
            c_n    = 1'b0;
            v_n    = 1'b0;
            wr_acc = 1'b1;
         end
         default: ;
      endcase
   end

   // One shift-add multiply step: add the multiplicand into the upper half when
   // the current multiplier bit is set, then shift the whole product right.
   always_comb begin
      step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_nxt = {step_sum, prod_q[WIDTH-1:1]};
   end

   // Control FSM plus all architectural state; done and bus_oe default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         hi_q    <= '0;
         for (int unsigned i = 0; i < unsigned'(NREGS); i++) b_q[i] <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         nf_q    <= 1'b0;
         vf_q    <= 1'b0;
         done_q  <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         done_q <= 1'b0;
         oe_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  done_q <= 1'b1;
                  case (op)
                     OP_LDB: begin
                        for (int unsigned i = 0; i < unsigned'(NREGS); i++) begin
                           if (cmd_sel == SELW'(i)) b_q[i] <= cmd_data;
                        end
                     end
                     OP_OUT: oe_q <= 1'b1;
                     OP_CLR: hi_q <= '0;
                     OP_MUL: begin
                        state_q <= S_MUL;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        mcand_q <= acc_q;
                        prod_q  <= {{WIDTH{1'b0}}, b_val};
                     end
                     default: ;
                  endcase
                  if (wr_acc) begin
                     acc_q <= res;
                     zf_q  <= (res == '0);
                     nf_q  <= res[WIDTH-1];
                     cf_q  <= c_n;
                     vf_q  <= v_n;
                  end
               end
            end
            S_MUL: begin
               prod_q <= prod_nxt;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  acc_q   <= prod_nxt[WIDTH-1:0];
                  hi_q    <= prod_nxt[2*WIDTH-1:WIDTH];
                  cf_q    <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                  vf_q    <= 1'b0;
                  zf_q    <= (prod_nxt[WIDTH-1:0] == '0);
                  nf_q    <= prod_nxt[WIDTH-1];
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
